core_sequencer: RTL
===================

// Module: core_sequencer
// PURPOSE
//  Top-level control unit sequencing the byte-serial execute stage on a single shared 8-bit memory port.
//  Fetches each 32-bit instruction byte-serially (big-endian) and presents it to execute.
//  Hands the memory port to execute until retire, then updates the PC.
//  Halts on an invalid instruction, a misaligned jump target or an external halt request.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC loaded on reset
//  NOP_INST   {25'b0,`NOP}   instruction driven to execute while not in S_EXEC (1-cycle no-op)
// PORTS
//  i_clk             in   1   clock
//  i_rst             in   1   reset: synchronous, active-high
//  o_mem_addr        out  32  shared memory byte address
//  o_mem_write       out  1   shared memory write strobe
//  o_mem_data        out  8   shared memory write data
//  i_mem_data        in   8   shared memory read data; read latency exactly 1 cycle
//  o_inst            out  32  instruction to execute
//  o_pc              out  32  PC of o_inst
//  i_exec_mem_addr   in   32  execute-side memory address
//  i_exec_mem_write  in   1   execute-side write strobe
//  i_exec_mem_data   in   8   execute-side write data
//  o_exec_mem_data   out  8   read data to execute; = i_mem_data always
//  i_exec_ready      in   1   execute last cycle of current instruction (retire at this edge)
//  i_exec_pc_change  in   1   execute requests jump/branch
//  i_exec_new_pc     in   32  jump/branch target
//  i_exec_invalid    in   1   execute flags o_inst invalid
//  i_halt_req        in   1   halt after current instruction retires
//  i_resume          in   1   leave S_HALT
//  o_halted          out  1   1 in S_HALT
//  o_halt_cause      out  2   0 none/ext, 1 invalid inst, 2 misaligned target
//  o_retired         out  32  retired-instruction counter, wraps at 2^32
// BEHAVIOUR
//  Reset: state S_FETCH, byte_cnt 0, pc RESET_PC, inst_buf 0.
//   Outputs: o_inst NOP_INST, o_halted 0, o_halt_cause 0, o_retired 0; memory drives per S_FETCH.
//   Reset mid-fetch or mid-exec abandons the operation; no retire counted.
//  S_FETCH: byte_cnt k=0..3.
//   o_mem_addr=pc+k, o_mem_write=0, o_mem_data=0, o_inst=NOP_INST.
//   From k>=1 capture byte k-1: inst_buf[31-8(k-1) -: 8] <= i_mem_data.
//   After k=3 -> S_FWAIT.
//  S_FWAIT: addr=pc+3 held (don't-care for memory), write=0.
//   Capture byte 3 into inst_buf[7:0] -> S_EXEC. Fetch costs exactly 5 cycles.
//  S_EXEC: o_inst=inst_buf; o_mem_* = i_exec_mem_* combinationally. Stay while !i_exec_ready.
//   At edge with i_exec_ready, priority order:
//   1. i_exec_invalid -> S_HALT, cause 1, pc unchanged, no retire count.
//   2. i_exec_pc_change && i_exec_new_pc[1:0]!=0 -> S_HALT, cause 2, pc unchanged, no count.
//   3. Otherwise: pc <= pc_change ? new_pc : pc+4 (mod 2^32); o_retired++;
//      -> S_HALT with cause 0 if i_halt_req, else S_FETCH with byte_cnt 0.
//   i_halt_req outside a retire edge is ignored (level must be held by requester).
//  S_HALT: o_inst=NOP_INST, o_mem_addr=0, write=0.
//   i_resume -> S_FETCH at current pc, cause cleared to 0. If i_halt_req and i_resume are both high, halt stays.
//  o_pc = pc in all states; o_exec_mem_data = i_mem_data in all states.
// STRUCTURE
//  common.svh: state enum {S_FETCH,S_FWAIT,S_EXEC,S_HALT}, HALT_* cause codes, MEM_RD_LATENCY=1.
//  Sub-module inst_byte_assembler: byte_cnt + inst_buf capture, done pulse.
//  core_sequencer: FSM, PC and retire counter, memory mux.
// TESTING
//  Reset, mem[0..3]=13 00 00 00 -> o_inst=32'h1300_0000 in cycle 5; addrs 0,1,2,3 in cycles 0-3.
//  Byte-wide ADDI then SW x1,0(x0): store bytes appear on o_mem_* while S_EXEC; i_exec_ready on last byte;
//   next fetch addr = 8; o_retired=2.
//  JAL target 0x40 -> next fetch from 0x40; JALR target 0x42 (after &~1) -> halted, cause 2, o_pc unchanged.
//  Undefined opcode 7'h7F -> o_halted=1, cause 1, o_retired unchanged; i_resume -> refetch same pc.
//  i_halt_req held during a 4-byte LW -> halt after it retires; cause 0, pc+4, o_retired incremented.
//  i_rst pulsed in fetch cycle 2 -> next cycle o_mem_addr=RESET_PC, o_retired=0; pc=0xFFFF_FFFC non-jump -> pc wraps to 0.

Source files
------------

// File: rtl/core_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : core_sequencer_pkg
//  Description : Shared state encoding, halt cause codes and fetch constants
//                for the byte-serial core sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package core_sequencer_pkg;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_FWAIT = 2'd1,
        S_EXEC  = 2'd2,
        S_HALT  = 2'd3
    } state_e;

    localparam logic [1:0]  HALT_NONE     = 2'd0;
    localparam logic [1:0]  HALT_INVALID  = 2'd1;
    localparam logic [1:0]  HALT_MISALIGN = 2'd2;

    localparam int          MEM_RD_LATENCY = 1;
    localparam logic [2:0]  FETCH_LAST_K   = 3'd3;
    localparam logic [2:0]  FETCH_BYTES    = 3'd4;

    localparam logic [6:0]  OP_NOP   = 7'h13;
    localparam logic [31:0] NOP_WORD = {25'b0, OP_NOP};

endpackage : core_sequencer_pkg
`default_nettype wire

// File: rtl/core_sequencer_assembler.sv
`default_nettype none
// ============================================================================
//  Module      : inst_byte_assembler
//  Description : Counts fetch bytes and assembles the big-endian instruction
//                word from the 1-cycle-latency byte read port.
//  Revision    : 1.0 - initial release
// ============================================================================
module inst_byte_assembler
    import core_sequencer_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_fetch,
    input  logic [7:0]  i_mem_data,
    output logic [2:0]  o_byte_cnt,
    output logic [31:0] o_inst_buf,
    output logic        o_done
);

    logic [2:0]  byte_cnt_q;
    logic [31:0] inst_buf_q;
    logic [1:0]  w_idx;

    // Data returning now belongs to the address issued MEM_RD_LATENCY cycles ago
    assign w_idx = 2'(byte_cnt_q - 3'(MEM_RD_LATENCY));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            byte_cnt_q <= 3'd0;
            inst_buf_q <= 32'd0;
        end else if (i_fetch) begin
            if (byte_cnt_q >= 3'(MEM_RD_LATENCY)) begin
                inst_buf_q[5'd31 - {w_idx, 3'b000} -: 8] <= i_mem_data;
            end
            byte_cnt_q <= (byte_cnt_q == FETCH_BYTES) ? 3'd0 : byte_cnt_q + 3'd1;
        end else begin
            byte_cnt_q <= 3'd0;
        end
    end

    assign o_byte_cnt = byte_cnt_q;
    assign o_inst_buf = inst_buf_q;
    assign o_done     = i_fetch && (byte_cnt_q == FETCH_BYTES);

endmodule : inst_byte_assembler
`default_nettype wire

// File: rtl/core_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : core_sequencer
//  Description : Fetch/execute sequencer sharing one 8-bit memory port between
//                byte-serial fetch and the execute stage; owns PC and retires.
//  Revision    : 1.0 - initial release
// ============================================================================
module core_sequencer
    import core_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = NOP_WORD
) (
    input  logic        i_clk,
    input  logic        i_rst,
    output logic [31:0] o_mem_addr,
    output logic        o_mem_write,
    output logic [7:0]  o_mem_data,
    input  logic [7:0]  i_mem_data,
    output logic [31:0] o_inst,
    output logic [31:0] o_pc,
    input  logic [31:0] i_exec_mem_addr,
    input  logic        i_exec_mem_write,
    input  logic [7:0]  i_exec_mem_data,
    output logic [7:0]  o_exec_mem_data,
    input  logic        i_exec_ready,
    input  logic        i_exec_pc_change,
    input  logic [31:0] i_exec_new_pc,
    input  logic        i_exec_invalid,
    input  logic        i_halt_req,
    input  logic        i_resume,
    output logic        o_halted,
    output logic [1:0]  o_halt_cause,
    output logic [31:0] o_retired
);

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] retired_q, retired_d;
    logic [1:0]  cause_q, cause_d;

    logic        w_fetch;
    logic [2:0]  w_byte_cnt;
    logic [31:0] w_inst_buf;
    logic        w_fetch_done;

    assign w_fetch = (state_q == S_FETCH) || (state_q == S_FWAIT);

    inst_byte_assembler u_asm (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_fetch    (w_fetch),
        .i_mem_data (i_mem_data),
        .o_byte_cnt (w_byte_cnt),
        .o_inst_buf (w_inst_buf),
        .o_done     (w_fetch_done)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= S_FETCH;
            pc_q      <= RESET_PC;
            retired_q <= 32'd0;
            cause_q   <= HALT_NONE;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            retired_q <= retired_d;
            cause_q   <= cause_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        retired_d = retired_q;
        cause_d   = cause_q;
        case (state_q)
            S_FETCH: begin
                if (w_byte_cnt == FETCH_LAST_K) state_d = S_FWAIT;
            end
            S_FWAIT: begin
                if (w_fetch_done) state_d = S_EXEC;
            end
            S_EXEC: begin
                // Faults take priority over retirement and leave PC pointing at the culprit
                if (i_exec_ready) begin
                    if (i_exec_invalid) begin
                        state_d = S_HALT;
                        cause_d = HALT_INVALID;
                    end else if (i_exec_pc_change && (i_exec_new_pc[1:0] != 2'b00)) begin
                        state_d = S_HALT;
                        cause_d = HALT_MISALIGN;
                    end else begin
                        pc_d      = i_exec_pc_change ? i_exec_new_pc : pc_q + 32'd4;
                        retired_d = retired_q + 32'd1;
                        if (i_halt_req) begin
                            state_d = S_HALT;
                            cause_d = HALT_NONE;
                        end else begin
                            state_d = S_FETCH;
                        end
                    end
                end
            end
            S_HALT: begin
                if (i_resume && !i_halt_req) begin
                    state_d = S_FETCH;
                    cause_d = HALT_NONE;
                end
            end
            default: state_d = S_FETCH;
        endcase
    end

    always_comb begin
        o_mem_addr  = pc_q + {29'd0, w_byte_cnt};
        o_mem_write = 1'b0;
        o_mem_data  = 8'd0;
        o_inst      = NOP_INST;
        case (state_q)
            S_FETCH: o_mem_addr = pc_q + {29'd0, w_byte_cnt};
            S_FWAIT: o_mem_addr = pc_q + 32'd3;
            S_EXEC: begin
                o_mem_addr  = i_exec_mem_addr;
                o_mem_write = i_exec_mem_write;
                o_mem_data  = i_exec_mem_data;
                o_inst      = w_inst_buf;
            end
            S_HALT:  o_mem_addr = 32'd0;
            default: o_mem_addr = 32'd0;
        endcase
    end

    assign o_pc            = pc_q;
    assign o_exec_mem_data = i_mem_data;
    assign o_halted        = (state_q == S_HALT);
    assign o_halt_cause    = cause_q;
    assign o_retired       = retired_q;

endmodule : core_sequencer
`default_nettype wire
